// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MAR/MDR memory access unit.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'h0000_DEAD;

    localparam logic MARMUX_DATAP    = 1'b0;
    localparam logic MARMUX_ADDR_SUM = 1'b1;

endpackage

// File: rtl/mem_timeout_counter.sv
// Saturating wait counter: expired rises once TIMEOUT un-acknowledged access cycles have elapsed.
module mem_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    assign expired = (count == LIMIT);

    // Holds at LIMIT rather than wrapping so expired stays asserted until cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR memory access unit with req/ack handshake to a variable-latency memory.
// Optional access timeout is compiled in with `define MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               ADDR_W   = 16,
    parameter int               TIMEOUT  = 255,
    parameter logic [WIDTH-1:0] ERR_DATA = WIDTH'(ERR_DATA_DEFAULT)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  DATAP,
    input  logic [ADDR_W-1:0] Addr_Sum,
    input  logic              MARMUX,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              Mem_Rd,
    input  logic              Mem_Wr,
    input  logic              Err_Clr,
    input  logic [WIDTH-1:0]  Mem_Rdata,
    input  logic              Mem_Ack,
    output logic              Mem_Req,
    output logic              Mem_We,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [WIDTH-1:0]  Mem_Wdata,
    output logic [ADDR_W-1:0] MAR,
    output logic [WIDTH-1:0]  MDR,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    state_t state;
    logic   timeout_hit;

    assign Mem_Addr  = MAR;
    assign Mem_Wdata = MDR;

`ifdef MEM_ACCESS_TIMEOUT_EN
    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (Clk),
        .rst_n   (Reset),
        .clear   (state != ACCESS),
        .enable  ((state == ACCESS) && !Mem_Ack),
        .expired (timeout_hit)
    );

    // An ack arriving together with expiry wins, so Err only sets on a true timeout.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Err <= 1'b0;
        end else if ((state == ACCESS) && timeout_hit && !Mem_Ack) begin
            Err <= 1'b1;
        end else if (Err_Clr) begin
            Err <= 1'b0;
        end
    end
`else
    logic unused_cfg;

    assign timeout_hit = 1'b0;
    assign Err         = 1'b0;
    assign unused_cfg  = ^{Err_Clr, TIMEOUT};
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            MAR     <= '0;
            MDR     <= '0;
            Mem_Req <= 1'b0;
            Mem_We  <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (LD_MAR) begin
                        MAR <= (MARMUX == MARMUX_ADDR_SUM) ? Addr_Sum : DATAP[ADDR_W-1:0];
                    end
                    if (LD_MDR) begin
                        MDR <= DATAP;
                    end
                    if (Mem_Rd || Mem_Wr) begin
                        state   <= ACCESS;
                        Mem_Req <= 1'b1;
                        Mem_We  <= !Mem_Rd;
                        Busy    <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (Mem_Ack || timeout_hit) begin
                        state   <= DONE;
                        Mem_Req <= 1'b0;
                        Mem_We  <= 1'b0;
                        Done    <= 1'b1;
                        if (!Mem_We) begin
                            MDR <= Mem_Ack ? Mem_Rdata : ERR_DATA;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    Mem_Req <= 1'b0;
                    Mem_We  <= 1'b0;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised MAR/MDR memory access unit replacing the fixed-width MAR/MDR registers and the single-cycle MIO_EN path of the current datapath. It captures addresses and data from the shared bus, then runs a request/acknowledge handshake with a variable-latency memory. Read data lands in MDR and completion is signalled to the control FSM. An optional timeout aborts accesses to an unresponsive memory.

## Interface
- WIDTH, 16: data width of the bus, MDR and memory data.
- ADDR_W, 16: address width of MAR and Mem_Addr. Must satisfy ADDR_W ≤ WIDTH.
- TIMEOUT, 255: maximum cycles Mem_Req may wait for Mem_Ack. Used only when the timeout is compiled in. Must be ≥ 1.
- ERR_DATA, 'hDEAD (truncated to WIDTH): value written to MDR on a timed-out read.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- DATAP  in  WIDTH  shared datapath bus.
- Addr_Sum  in  ADDR_W  address-adder result.
- MARMUX  in  1  MAR source: 0 = DATAP[ADDR_W-1:0], 1 = Addr_Sum.
- LD_MAR  in  1  load MAR.
- LD_MDR  in  1  load MDR from DATAP.
- Mem_Rd  in  1  start a read (sampled level; one access per accepted cycle).
- Mem_Wr  in  1  start a write.
- Err_Clr  in  1  clear sticky Err.
- Mem_Rdata  in  WIDTH  memory read data, valid with Mem_Ack.
- Mem_Ack  in  1  memory acknowledge.
- Mem_Req  out  1  access request.
- Mem_We  out  1  1 = write; valid while Mem_Req is high.
- Mem_Addr  out  ADDR_W  always equals MAR.
- Mem_Wdata  out  WIDTH  always equals MDR.
- MAR  out  ADDR_W  address register.
- MDR  out  WIDTH  data register.
- Busy  out  1  high in ACCESS and DONE.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  sticky timeout flag.

## Operation
- FSM states:
  - IDLE: Busy=0, Mem_Req=0. Mem_Rd or Mem_Wr → ACCESS. If both are high, the read wins and Mem_We=0.
  - ACCESS: Mem_Req=1, Mem_We is held for the whole access. Mem_Ack → DONE. On a read, MDR ← Mem_Rdata at that edge.
  - DONE: Done=1 for one cycle, then → IDLE.
- While in IDLE, LD_MAR and LD_MDR load on the edge. While Busy, LD_MAR, LD_MDR, Mem_Rd and Mem_Wr are ignored, so MAR and MDR stay stable for the whole access.
- A load in the same IDLE cycle as a request is accepted, and the access uses the newly loaded MAR/MDR.
- Mem_Ack is ignored outside ACCESS.
- Err_Clr clears Err at the edge. If a timeout occurs on the same edge, the set wins.

## Timing
- Reset (asynchronous assert) puts every output at 0:
  - state = IDLE;
  - MAR = 0, MDR = 0;
  - Mem_Req, Mem_We, Busy, Done and Err all low.
- Reset released mid-access returns the unit to IDLE with no Done pulse.
- Request sampled at edge 0 → Mem_Req high from cycle 1.
- Ack sampled at edge k (k ≥ 1) → MDR updated and Done high in cycle k+1. Busy is high in cycles 1..k+1.
- Minimum request-to-Done latency is 2 cycles. The earliest next request is accepted in the cycle after Done.
- Timeout counter: cleared on entry to ACCESS and incremented every ACCESS cycle without Ack. Its width is $clog2(TIMEOUT+1) and it never wraps.

## Configuration
- MEM_ACCESS_TIMEOUT_EN defined:
  - if the counter reaches TIMEOUT with no Ack, go to DONE and set Err;
  - a timed-out read loads ERR_DATA into MDR; a timed-out write leaves MDR unchanged;
  - an Ack in the same cycle the counter hits TIMEOUT counts as a normal completion.
- Undefined: ACCESS waits for Ack indefinitely, Err is tied to 0, and no counter logic is present.

## Structure
- Package mem_access_pkg holds:
  - the state enum (IDLE, ACCESS, DONE);
  - the default ERR_DATA constant;
  - the MARMUX encoding constants.
- Sub-module mem_timeout_counter (parameter TIMEOUT; inputs clear and enable; output expired) is instantiated only under MEM_ACCESS_TIMEOUT_EN.

## Test plan
- Basic read, applied after reset: LD_MAR with DATAP=16'h3000, then Mem_Rd; Mem_Ack arrives on the 3rd ACCESS cycle with Mem_Rdata=16'hBEEF. Required: Mem_Addr=16'h3000, MDR=16'hBEEF, one Done pulse, Busy high for 4 cycles.
- Write with combined loads: LD_MDR with 16'h1234, MARMUX=1 with Addr_Sum=16'h0042, and Mem_Wr all in the same cycle. Required: Mem_We=1, Mem_Addr=16'h0042, Mem_Wdata=16'h1234; MDR is still 16'h1234 after Done.
- Collision and busy-ignore: Mem_Rd and Mem_Wr high together → Mem_We=0. LD_MDR with 16'hFFFF during Busy → MDR is unaffected. Mem_Ack while IDLE → no state change.
- Timeout (macro defined, TIMEOUT=4): Mem_Rd with no Ack → Done in cycle 6, MDR=16'hDEAD, Err=1. Err_Clr → Err=0.
- Reset mid-access: Reset taken low while Mem_Req=1 → Mem_Req, Busy and MAR drop to 0 immediately; after release the unit sits in IDLE and a new read completes normally.
